// File: rtl/exec_sched_pkg.sv
// Shared types and default sizing for the executor scheduler.
package exec_sched_pkg;

    typedef enum logic [1:0] {SLOT_IDLE, SLOT_BUSY, SLOT_DONE} slot_state_e;

    localparam int unsigned DEFAULT_NUM_EXEC = 4;
    localparam int unsigned DEFAULT_TAG_W    = 8;

endpackage

// File: rtl/exec_scheduler_rr_pick.sv
// Circular priority pick: first set bit of i_idle at or after i_ptr, wrapping.
module rr_pick
    import exec_sched_pkg::*;
#(
    parameter int unsigned NUM_EXEC = DEFAULT_NUM_EXEC,
    parameter int unsigned SEL_W    = $clog2(NUM_EXEC)
) (
    input  logic [NUM_EXEC-1:0] i_idle,
    input  logic [SEL_W-1:0]    i_ptr,
    output logic                o_found,
    output logic [SEL_W-1:0]    o_sel
);

    logic [SEL_W-1:0] w_idx;

    // NUM_EXEC is a power of two, so the index wraps by truncation.
    always_comb begin
        o_found = 1'b0;
        o_sel   = '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < NUM_EXEC; i++) begin
            w_idx = i_ptr + SEL_W'(i);
            if (!o_found && i_idle[w_idx]) begin
                o_found = 1'b1;
                o_sel   = w_idx;
            end
        end
    end

endmodule

// File: rtl/exec_scheduler.sv
// Round-robin job dispatch over an executor bank with in-order retirement
// and drain-gated op-table update broadcast.
module exec_scheduler
    import exec_sched_pkg::*;
#(
    parameter int unsigned NUM_EXEC = DEFAULT_NUM_EXEC,
    parameter int unsigned TAG_W    = DEFAULT_TAG_W,
    parameter int unsigned SEL_W    = $clog2(NUM_EXEC)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [TAG_W-1:0]    tag_i,
    output logic                ready_o,
    output logic [NUM_EXEC-1:0] exec_start_o,
    output logic [SEL_W-1:0]    exec_sel_o,
    input  logic [NUM_EXEC-1:0] exec_ready_i,
    output logic                done_o,
    output logic [TAG_W-1:0]    done_tag_o,
    output logic [SEL_W-1:0]    done_exec_o,
    input  logic                mod_start_i,
    output logic                mod_pending_o,
    output logic                exec_mod_start_o,
    output logic                idle_o,
    output logic                spurious_o
);

    localparam int unsigned CNT_W = SEL_W + 1;

    slot_state_e         r_state [NUM_EXEC];
    logic [TAG_W-1:0]    r_tag   [NUM_EXEC];
    logic [SEL_W-1:0]    r_fifo  [NUM_EXEC];
    logic [SEL_W-1:0]    r_head;
    logic [SEL_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;
    logic [SEL_W-1:0]    r_rr_ptr;
    logic                r_mod_pending;
    logic [NUM_EXEC-1:0] r_exec_start;
    logic [SEL_W-1:0]    r_exec_sel;
    logic                r_done;
    logic [TAG_W-1:0]    r_done_tag;
    logic [SEL_W-1:0]    r_done_exec;
    logic                r_exec_mod_start;
    logic                r_spurious;

    logic [NUM_EXEC-1:0] w_idle_mask;
    logic                w_found;
    logic [SEL_W-1:0]    w_sel;
    logic [SEL_W-1:0]    w_head_slot;
    logic                w_all_idle;
    logic                w_accept;
    logic                w_retire;

    always_comb begin
        w_idle_mask = '0;
        for (int unsigned k = 0; k < NUM_EXEC; k++) begin
            w_idle_mask[k] = (r_state[k] == SLOT_IDLE);
        end
    end

    rr_pick #(
        .NUM_EXEC (NUM_EXEC),
        .SEL_W    (SEL_W)
    ) u_rr_pick (
        .i_idle  (w_idle_mask),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_sel   (w_sel)
    );

    // A completion arriving on the head slot retires in the same cycle.
    assign w_head_slot = r_fifo[r_head];
    assign w_retire    = (r_count != '0) &&
                         ((r_state[w_head_slot] == SLOT_DONE) ||
                          ((r_state[w_head_slot] == SLOT_BUSY) && exec_ready_i[w_head_slot]));
    assign w_all_idle  = (&w_idle_mask) && (r_count == '0);
    assign ready_o     = !rst && !r_mod_pending && !mod_start_i && w_found;
    assign w_accept    = start_i && ready_o;
    assign idle_o      = !rst && w_all_idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_EXEC; k++) begin
                r_state[k] <= SLOT_IDLE;
                r_tag[k]   <= '0;
                r_fifo[k]  <= '0;
            end
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            r_rr_ptr         <= '0;
            r_mod_pending    <= 1'b0;
            r_exec_start     <= '0;
            r_exec_sel       <= '0;
            r_done           <= 1'b0;
            r_done_tag       <= '0;
            r_done_exec      <= '0;
            r_exec_mod_start <= 1'b0;
            r_spurious       <= 1'b0;
        end else begin
            r_exec_start     <= '0;
            r_exec_sel       <= '0;
            r_done           <= 1'b0;
            r_done_tag       <= '0;
            r_done_exec      <= '0;
            r_exec_mod_start <= 1'b0;

            for (int unsigned k = 0; k < NUM_EXEC; k++) begin
                if (exec_ready_i[k]) begin
                    if (r_state[k] == SLOT_BUSY) r_state[k] <= SLOT_DONE;
                    else                         r_spurious <= 1'b1;
                end
            end

            if (w_accept) begin
                r_state[w_sel]       <= SLOT_BUSY;
                r_tag[w_sel]         <= tag_i;
                r_fifo[r_tail]       <= w_sel;
                r_tail               <= r_tail + SEL_W'(1);
                r_rr_ptr             <= w_sel + SEL_W'(1);
                r_exec_start[w_sel]  <= 1'b1;
                r_exec_sel           <= w_sel;
            end

            // Overrides the BUSY->DONE write above when the head completes now.
            if (w_retire) begin
                r_state[w_head_slot] <= SLOT_IDLE;
                r_done               <= 1'b1;
                r_done_tag           <= r_tag[w_head_slot];
                r_done_exec          <= w_head_slot;
                r_head               <= r_head + SEL_W'(1);
            end

            r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_retire);

            if (r_mod_pending) begin
                if (w_all_idle) begin
                    r_exec_mod_start <= 1'b1;
                    r_mod_pending    <= 1'b0;
                end
            end else if (mod_start_i) begin
                if (w_all_idle) r_exec_mod_start <= 1'b1;
                else            r_mod_pending    <= 1'b1;
            end
        end
    end

    assign exec_start_o     = r_exec_start;
    assign exec_sel_o       = r_exec_sel;
    assign done_o           = r_done;
    assign done_tag_o       = r_done_tag;
    assign done_exec_o      = r_done_exec;
    assign mod_pending_o    = r_mod_pending;
    assign exec_mod_start_o = r_exec_mod_start;
    assign spurious_o       = r_spurious;

endmodule

// File: tb/tb_exec_scheduler.sv
// Self-checking bench for exec_scheduler: vector table, directed corner cases,
// and random traffic against a queue-based job model.
module tb_exec_scheduler;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i;
    logic [7:0]   tag_i;
    logic         ready_o;
    logic [3:0]   exec_start_o;
    logic [1:0]   exec_sel_o;
    logic [3:0]   exec_ready_i;
    logic         done_o;
    logic [7:0]   done_tag_o;
    logic [1:0]   done_exec_o;
    logic         mod_start_i;
    logic         mod_pending_o;
    logic         exec_mod_start_o;
    logic         idle_o;
    logic         spurious_o;

    always #5 clk = ~clk;

    exec_scheduler #(
        .NUM_EXEC (4),
        .TAG_W    (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .tag_i            (tag_i),
        .ready_o          (ready_o),
        .exec_start_o     (exec_start_o),
        .exec_sel_o       (exec_sel_o),
        .exec_ready_i     (exec_ready_i),
        .done_o           (done_o),
        .done_tag_o       (done_tag_o),
        .done_exec_o      (done_exec_o),
        .mod_start_i      (mod_start_i),
        .mod_pending_o    (mod_pending_o),
        .exec_mod_start_o (exec_mod_start_o),
        .idle_o           (idle_o),
        .spurious_o       (spurious_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int mod_pulses;
    logic last_ready;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the in-flight jobs in dispatch order; a slot is free iff no job holds it.
    int         q_slot[$];
    logic [7:0] q_tag[$];
    bit         q_done[$];
    int         m_rr;
    bit         m_pend;
    bit         m_spur;
    bit         x_ready, x_idle, x_done, x_mod;
    logic [3:0] x_start;
    logic [1:0] x_sel, x_dexec;
    logic [7:0] x_dtag;

    function automatic bit m_occupied(input int s);
        foreach (q_slot[j]) if (q_slot[j] == s) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q_slot.delete();
        q_tag.delete();
        q_done.delete();
        m_rr   = 0;
        m_pend = 1'b0;
        m_spur = 1'b0;
    endtask

    task automatic model_cycle(input bit st, input logic [7:0] tg, input logic [3:0] rdy,
                               input bit md);
        bit was_idle;
        bit head_ret;
        int sel;
        was_idle = (q_slot.size() == 0);
        x_ready  = !m_pend && !md && (q_slot.size() < N);
        x_idle   = was_idle;
        head_ret = (q_slot.size() > 0) && (q_done[0] || rdy[q_slot[0]]);
        sel      = -1;
        x_start  = '0;
        x_sel    = '0;
        x_done   = 1'b0;
        x_dtag   = '0;
        x_dexec  = '0;
        x_mod    = 1'b0;
        if (st && x_ready) begin
            for (int i = 0; i < N; i++) begin
                if (sel < 0 && !m_occupied((m_rr + i) % N)) sel = (m_rr + i) % N;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (rdy[k]) begin
                int idx;
                idx = -1;
                foreach (q_slot[j]) if (q_slot[j] == k) idx = j;
                if (idx < 0 || q_done[idx]) m_spur = 1'b1;
                else q_done[idx] = 1'b1;
            end
        end
        if (head_ret) begin
            x_done  = 1'b1;
            x_dtag  = q_tag[0];
            x_dexec = 2'(q_slot[0]);
            void'(q_slot.pop_front());
            void'(q_tag.pop_front());
            void'(q_done.pop_front());
        end
        if (sel >= 0) begin
            q_slot.push_back(sel);
            q_tag.push_back(tg);
            q_done.push_back(1'b0);
            m_rr    = (sel + 1) % N;
            x_start = 4'(1 << sel);
            x_sel   = 2'(sel);
        end
        if (m_pend) begin
            if (was_idle) begin
                x_mod  = 1'b1;
                m_pend = 1'b0;
            end
        end else if (md) begin
            if (was_idle) x_mod  = 1'b1;
            else          m_pend = 1'b1;
        end
    endtask

    task automatic drive_cycle(input bit st, input logic [7:0] tg, input logic [3:0] rdy,
                               input bit md);
        start_i      = st;
        tag_i        = tg;
        exec_ready_i = rdy;
        mod_start_i  = md;
        model_cycle(st, tg, rdy, md);
        #1;
        last_ready = ready_o;
        chk("ready_o", 32'(ready_o), 32'(x_ready));
        chk("idle_o", 32'(idle_o), 32'(x_idle));
        @(posedge clk);
        #1;
        chk("exec_start_o", 32'(exec_start_o), 32'(x_start));
        if (x_start != 4'b0000) chk("exec_sel_o", 32'(exec_sel_o), 32'(x_sel));
        chk("done_o", 32'(done_o), 32'(x_done));
        if (x_done) begin
            chk("done_tag_o", 32'(done_tag_o), 32'(x_dtag));
            chk("done_exec_o", 32'(done_exec_o), 32'(x_dexec));
        end
        chk("exec_mod_start_o", 32'(exec_mod_start_o), 32'(x_mod));
        chk("mod_pending_o", 32'(mod_pending_o), 32'(m_pend));
        chk("spurious_o", 32'(spurious_o), 32'(m_spur));
        if (exec_mod_start_o) mod_pulses++;
        start_i      = 1'b0;
        exec_ready_i = '0;
        mod_start_i  = 1'b0;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        start_i      = 1'b0;
        tag_i        = '0;
        exec_ready_i = '0;
        mod_start_i  = 1'b0;
        #1;
        chk("rst ready_o", 32'(ready_o), 32'd0);
        chk("rst idle_o", 32'(idle_o), 32'd0);
        @(posedge clk);
        #1;
        chk("rst exec_start_o", 32'(exec_start_o), 32'd0);
        chk("rst done_o", 32'(done_o), 32'd0);
        chk("rst done_tag_o", 32'(done_tag_o), 32'd0);
        chk("rst mod_pending_o", 32'(mod_pending_o), 32'd0);
        chk("rst exec_mod_start_o", 32'(exec_mod_start_o), 32'd0);
        chk("rst spurious_o", 32'(spurious_o), 32'd0);
        chk("rst idle_o held", 32'(idle_o), 32'd0);
        rst = 1'b0;
        model_reset();
        #1;
        chk("post-rst idle_o", 32'(idle_o), 32'd1);
    endtask

    typedef struct {
        bit         st;
        logic [7:0] tg;
        logic [3:0] rdy;
        bit         e_ready;
        logic [3:0] e_start;
        bit         e_done;
        logic [7:0] e_tag;
    } vec_t;

    vec_t tbl[22];

    initial begin
        start_i      = 1'b0;
        tag_i        = '0;
        exec_ready_i = '0;
        mod_start_i  = 1'b0;
        mod_pulses   = 0;
        last_ready   = 1'b0;
        model_reset();

        // Fill, overflow attempt, out-of-order completion, then wrap-around pick.
        tbl[0]  = '{1'b1, 8'h10, 4'b0000, 1'b1, 4'b0001, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 8'h11, 4'b0000, 1'b1, 4'b0010, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 8'h12, 4'b0000, 1'b1, 4'b0100, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 8'h13, 4'b0000, 1'b1, 4'b1000, 1'b0, 8'h00};
        tbl[4]  = '{1'b1, 8'h14, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 8'h00, 4'b1000, 1'b0, 4'b0000, 1'b0, 8'h00};
        tbl[6]  = '{1'b0, 8'h00, 4'b0010, 1'b0, 4'b0000, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 8'h00, 4'b0001, 1'b0, 4'b0000, 1'b1, 8'h10};
        tbl[8]  = '{1'b0, 8'h00, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'h11};
        tbl[9]  = '{1'b0, 8'h00, 4'b0100, 1'b1, 4'b0000, 1'b1, 8'h12};
        tbl[10] = '{1'b0, 8'h00, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'h13};
        tbl[11] = '{1'b1, 8'h20, 4'b0000, 1'b1, 4'b0001, 1'b0, 8'h00};
        tbl[12] = '{1'b1, 8'h21, 4'b0000, 1'b1, 4'b0010, 1'b0, 8'h00};
        tbl[13] = '{1'b1, 8'h22, 4'b0000, 1'b1, 4'b0100, 1'b0, 8'h00};
        tbl[14] = '{1'b0, 8'h00, 4'b0001, 1'b1, 4'b0000, 1'b1, 8'h20};
        tbl[15] = '{1'b1, 8'h23, 4'b0000, 1'b1, 4'b1000, 1'b0, 8'h00};
        tbl[16] = '{1'b1, 8'h24, 4'b0000, 1'b1, 4'b0001, 1'b0, 8'h00};
        tbl[17] = '{1'b0, 8'h00, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h21};
        tbl[18] = '{1'b0, 8'h00, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'h22};
        tbl[19] = '{1'b0, 8'h00, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'h23};
        tbl[20] = '{1'b0, 8'h00, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'h24};
        tbl[21] = '{1'b0, 8'h00, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00};

        do_reset();

        for (int i = 0; i < 22; i++) begin
            drive_cycle(tbl[i].st, tbl[i].tg, tbl[i].rdy, 1'b0);
            chk($sformatf("vec%0d ready", i), 32'(last_ready), 32'(tbl[i].e_ready));
            chk($sformatf("vec%0d start", i), 32'(exec_start_o), 32'(tbl[i].e_start));
            chk($sformatf("vec%0d done", i), 32'(done_o), 32'(tbl[i].e_done));
            if (tbl[i].e_done) chk($sformatf("vec%0d tag", i), 32'(done_tag_o), 32'(tbl[i].e_tag));
        end

        // Update request with two jobs in flight, merged second request.
        mod_pulses = 0;
        drive_cycle(1'b1, 8'h30, 4'b0000, 1'b0);
        drive_cycle(1'b1, 8'h31, 4'b0000, 1'b0);
        drive_cycle(1'b0, 8'h00, 4'b0000, 1'b1);
        chk("mod pending set", 32'(mod_pending_o), 32'd1);
        drive_cycle(1'b1, 8'h32, 4'b0000, 1'b0);
        chk("pending blocks ready", 32'(last_ready), 32'd0);
        chk("pending blocks start", 32'(exec_start_o), 32'd0);
        drive_cycle(1'b0, 8'h00, 4'b0000, 1'b1);
        drive_cycle(1'b0, 8'h00, 4'b0010, 1'b0);
        chk("no early broadcast", 32'(mod_pulses), 32'd0);
        drive_cycle(1'b0, 8'h00, 4'b0100, 1'b0);
        chk("drain retire tag", 32'(done_tag_o), 32'h31);
        drive_cycle(1'b0, 8'h00, 4'b0000, 1'b0);
        chk("broadcast after idle", 32'(exec_mod_start_o), 32'd1);
        chk("pending cleared", 32'(mod_pending_o), 32'd0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 8'h00, 4'b0000, 1'b0);
        chk("single broadcast", 32'(mod_pulses), 32'd1);

        // Start and update together while idle: update wins, job retried later.
        drive_cycle(1'b1, 8'h40, 4'b0000, 1'b1);
        chk("collide ready", 32'(last_ready), 32'd0);
        chk("collide no start", 32'(exec_start_o), 32'd0);
        chk("collide broadcast", 32'(exec_mod_start_o), 32'd1);
        drive_cycle(1'b1, 8'h40, 4'b0000, 1'b0);
        chk("retry start", 32'(exec_start_o), 32'b1000);
        drive_cycle(1'b0, 8'h00, 4'b1000, 1'b0);
        chk("retry done tag", 32'(done_tag_o), 32'h40);

        // Completion on an idle slot is sticky.
        drive_cycle(1'b0, 8'h00, 4'b0100, 1'b0);
        chk("spurious set", 32'(spurious_o), 32'd1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 8'h00, 4'b0000, 1'b0);
        chk("spurious held", 32'(spurious_o), 32'd1);

        // Reset with three jobs in flight abandons them.
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'(8'h50 + i), 4'b0000, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 8'h00, 4'b0111, 1'b0);
            chk("no done after rst", 32'(done_o), 32'd0);
        end
        do_reset();

        for (int c = 0; c < 1500; c++) begin
            drive_cycle(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom & $urandom),
                        ($urandom_range(0, 31) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
